// File: rtl/sdram_fb_pkg.sv
// sdram_fb_pkg: shared definitions for the frame-buffer SDRAM controller.
//   - SDRAM command encodings as {rasn, casn, wen}
//   - mode-register words for CAS latency 2 and 3 (burst length 1, sequential)
//   - controller state enum
package sdram_fb_pkg;

    localparam logic [2:0] CMD_LOADMODE  = 3'b000;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_NOP       = 3'b111;

    localparam logic [12:0] MODE_CL2 = 13'h020;
    localparam logic [12:0] MODE_CL3 = 13'h030;

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_INIT_PRE,
        S_INIT_REF1,
        S_INIT_REF2,
        S_INIT_MODE,
        S_IDLE,
        S_REFRESH,
        S_ACCESS
    } state_t;

    function automatic logic [12:0] mode_word(input int cas_latency);
        return (cas_latency == 3) ? MODE_CL3 : MODE_CL2;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: auto-refresh interval timer.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   en            counting enabled (controller initialised)
//   clr           refresh command issued this cycle; clears pending
//   pending       refresh owed; stays set until cleared
// The counter reloads with REFRESH_CYCLES-1 so that, while the controller is
// idle, REFRESH commands are exactly REFRESH_CYCLES cycles apart.
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 960
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pending
);

    localparam logic [15:0] RELOAD = 16'(REFRESH_CYCLES - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= RELOAD;
            pending <= 1'b0;
        end else begin
            if (!en || cnt == 16'd0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - 16'd1;
            end
            // a new expiry wins over a simultaneous clear
            if (en && cnt == 16'd0) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_fb_ctrl.sv
// sdram_fb_ctrl: single-port SDRAM controller for the frame-buffer path.
// Arbitrates one-word read (VGA refill) and write (C64 pixel) requests,
// runs power-up init and periodic auto-refresh, drives the SDRAM pins.
// Ports:
//   clk, rst                    125 MHz clock, asynchronous active-high reset
//   i_rd_req/o_rd_gnt/i_rd_addr read request, one-cycle grant, word address
//   o_rd_data/o_rd_data_valid   read word and its one-cycle strobe
//   i_wr_req/o_wr_gnt           write request and one-cycle grant
//   i_wr_addr/i_wr_data         write address and data
//   o_ready                     init complete
//   o_sdram_*/i_sdram_dq        SDRAM pins (csn tied low outside)
// Build option: SDRAM_FAST_INIT_EN shortens the power-up wait to 16 cycles.
//
// state       | meaning
// ------------+-----------------------------------------------------
// INIT_WAIT   | power-up NOPs with cke high
// INIT_PRE    | precharge all, T_RP cycles
// INIT_REF1/2 | two auto-refreshes, T_RFC cycles each
// INIT_MODE   | load mode register, 2 cycles
// IDLE        | arbitrate: refresh > read > write
// REFRESH     | auto-refresh, T_RFC cycles
// ACCESS      | ACTIVE, READ/WRITE at +T_RCD, ACCESS_CYCLES total
//
// All pin outputs and grants are registered from the next-state logic, so a
// state's command appears in its first cycle. The last cycle of ACCESS and
// REFRESH arbitrates like IDLE, giving one access per ACCESS_CYCLES.
module sdram_fb_ctrl
    import sdram_fb_pkg::*;
#(
    parameter int INIT_WAIT      = 25000,
    parameter int REFRESH_CYCLES = 960,
    parameter int T_RCD          = 2,
    parameter int T_RFC          = 8,
    parameter int T_RP           = 2,
    parameter int CAS_LATENCY    = 2,
    parameter int ACCESS_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_req,
    output logic        o_rd_gnt,
    input  logic [15:0] i_rd_addr,
    output logic [15:0] o_rd_data,
    output logic        o_rd_data_valid,
    input  logic        i_wr_req,
    output logic        o_wr_gnt,
    input  logic [15:0] i_wr_addr,
    input  logic [15:0] i_wr_data,
    output logic        o_ready,
    output logic        o_sdram_cke,
    output logic        o_sdram_rasn,
    output logic        o_sdram_casn,
    output logic        o_sdram_wen,
    output logic [12:0] o_sdram_a,
    output logic [1:0]  o_sdram_ba,
    output logic [1:0]  o_sdram_dqm,
    output logic [15:0] o_sdram_dq,
    output logic        o_sdram_dq_oe,
    input  logic [15:0] i_sdram_dq
);

`ifdef SDRAM_FAST_INIT_EN
    localparam int INIT_WAIT_EFF = 16;
`else
    localparam int INIT_WAIT_EFF = INIT_WAIT;
`endif

    localparam logic [15:0] T_RP_M1  = 16'(T_RP - 1);
    localparam logic [15:0] T_RFC_M1 = 16'(T_RFC - 1);
    localparam logic [15:0] ACC_M1   = 16'(ACCESS_CYCLES - 1);
    // timer value one cycle before the READ/WRITE cycle
    localparam logic [15:0] RW_PREV  = 16'(ACCESS_CYCLES - T_RCD);
    localparam logic [12:0] A10      = 13'h400;

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [12:0] a_q, a_d;
    logic [15:0] dq_q, dq_d;
    logic        dq_oe_q, dq_oe_d;
    logic        rd_gnt_q, rd_gnt_d;
    logic        wr_gnt_q, wr_gnt_d;
    logic        cke_q, ready_q, ready_d;
    logic [1:0]  dqm_q;
    logic [15:0] addr_q, data_q;
    logic        is_wr_q;
    logic        lat_en, lat_wr;
    logic [15:0] lat_addr, lat_data;
    logic        arb_go, ref_clr, ref_pending;
    logic [CAS_LATENCY-1:0] rd_pipe_q;
    logic [15:0] rd_data_q;
    logic        rd_valid_q;

    sdram_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (ready_q),
        .clr     (ref_clr),
        .pending (ref_pending)
    );

    always_comb begin
        state_d  = state_q;
        tmr_d    = (tmr_q != 16'd0) ? tmr_q - 16'd1 : 16'd0;
        cmd_d    = CMD_NOP;
        a_d      = '0;
        dq_d     = '0;
        dq_oe_d  = 1'b0;
        rd_gnt_d = 1'b0;
        wr_gnt_d = 1'b0;
        ref_clr  = 1'b0;
        lat_en   = 1'b0;
        lat_wr   = is_wr_q;
        lat_addr = addr_q;
        lat_data = data_q;
        arb_go   = 1'b0;

        case (state_q)
            S_INIT_WAIT: begin
                if (tmr_q == 16'd0) begin
                    state_d = S_INIT_PRE;
                    tmr_d   = T_RP_M1;
                    cmd_d   = CMD_PRECHARGE;
                    a_d     = A10;
                end
            end
            S_INIT_PRE: begin
                if (tmr_q == 16'd0) begin
                    state_d = S_INIT_REF1;
                    tmr_d   = T_RFC_M1;
                    cmd_d   = CMD_REFRESH;
                end
            end
            S_INIT_REF1: begin
                if (tmr_q == 16'd0) begin
                    state_d = S_INIT_REF2;
                    tmr_d   = T_RFC_M1;
                    cmd_d   = CMD_REFRESH;
                end
            end
            S_INIT_REF2: begin
                if (tmr_q == 16'd0) begin
                    state_d = S_INIT_MODE;
                    tmr_d   = 16'd1;
                    cmd_d   = CMD_LOADMODE;
                    a_d     = mode_word(CAS_LATENCY);
                end
            end
            S_INIT_MODE: begin
                if (tmr_q == 16'd0) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                arb_go = 1'b1;
            end
            S_REFRESH: begin
                arb_go = (tmr_q == 16'd0);
            end
            S_ACCESS: begin
                if (tmr_q == 16'd0) begin
                    arb_go = 1'b1;
                end else if (tmr_q == RW_PREV) begin
                    cmd_d = is_wr_q ? CMD_WRITE : CMD_READ;
                    a_d   = A10 | {5'b0, addr_q[7:0]};
                    if (is_wr_q) begin
                        dq_d    = data_q;
                        dq_oe_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_INIT_WAIT;
            end
        endcase

        if (arb_go) begin
            if (ref_pending) begin
                state_d = S_REFRESH;
                tmr_d   = T_RFC_M1;
                cmd_d   = CMD_REFRESH;
                ref_clr = 1'b1;
            end else if (i_rd_req) begin
                state_d  = S_ACCESS;
                tmr_d    = ACC_M1;
                cmd_d    = CMD_ACTIVE;
                a_d      = {5'b0, i_rd_addr[15:8]};
                rd_gnt_d = 1'b1;
                lat_en   = 1'b1;
                lat_wr   = 1'b0;
                lat_addr = i_rd_addr;
            end else if (i_wr_req) begin
                state_d  = S_ACCESS;
                tmr_d    = ACC_M1;
                cmd_d    = CMD_ACTIVE;
                a_d      = {5'b0, i_wr_addr[15:8]};
                wr_gnt_d = 1'b1;
                lat_en   = 1'b1;
                lat_wr   = 1'b1;
                lat_addr = i_wr_addr;
                lat_data = i_wr_data;
            end else begin
                state_d = S_IDLE;
                tmr_d   = 16'd0;
            end
        end

        ready_d = (state_d == S_IDLE) || (state_d == S_REFRESH) || (state_d == S_ACCESS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT_WAIT;
            tmr_q      <= 16'(INIT_WAIT_EFF);
            cke_q      <= 1'b0;
            cmd_q      <= CMD_NOP;
            a_q        <= '0;
            dqm_q      <= 2'b11;
            dq_q       <= '0;
            dq_oe_q    <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            is_wr_q    <= 1'b0;
            rd_pipe_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cke_q      <= 1'b1;
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            dqm_q      <= ready_d ? 2'b00 : 2'b11;
            dq_q       <= dq_d;
            dq_oe_q    <= dq_oe_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            ready_q    <= ready_d;
            if (lat_en) begin
                addr_q  <= lat_addr;
                data_q  <= lat_data;
                is_wr_q <= lat_wr;
            end
            // READ seen on the pins, aged until the SDRAM drives its data
            rd_pipe_q  <= {rd_pipe_q[CAS_LATENCY-2:0], cmd_q == CMD_READ};
            rd_valid_q <= rd_pipe_q[CAS_LATENCY-1];
            if (rd_pipe_q[CAS_LATENCY-1]) begin
                rd_data_q <= i_sdram_dq;
            end
        end
    end

    assign o_rd_gnt        = rd_gnt_q;
    assign o_wr_gnt        = wr_gnt_q;
    assign o_rd_data       = rd_data_q;
    assign o_rd_data_valid = rd_valid_q;
    assign o_ready         = ready_q;
    assign o_sdram_cke     = cke_q;
    assign o_sdram_rasn    = cmd_q[2];
    assign o_sdram_casn    = cmd_q[1];
    assign o_sdram_wen     = cmd_q[0];
    assign o_sdram_a       = a_q;
    assign o_sdram_ba      = 2'b00;
    assign o_sdram_dqm     = dqm_q;
    assign o_sdram_dq      = dq_q;
    assign o_sdram_dq_oe   = dq_oe_q;

endmodule

// File: tb/tb_sdram_fb_ctrl.sv
// tb_sdram_fb_ctrl: directed bench for sdram_fb_ctrl with a small SDRAM
// behavioural model (row latch, word memory, CL2 read return).
module tb_sdram_fb_ctrl;

    localparam int TB_INIT_WAIT = 40;
`ifdef SDRAM_FAST_INIT_EN
    localparam int EXP_WAIT = 16;
`else
    localparam int EXP_WAIT = TB_INIT_WAIT;
`endif
    localparam int TB_REFRESH = 150;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        clk, rst;
    logic        i_rd_req, o_rd_gnt, o_rd_data_valid;
    logic [15:0] i_rd_addr, o_rd_data;
    logic        i_wr_req, o_wr_gnt;
    logic [15:0] i_wr_addr, i_wr_data;
    logic        o_ready, o_sdram_cke, o_sdram_rasn, o_sdram_casn, o_sdram_wen;
    logic [12:0] o_sdram_a;
    logic [1:0]  o_sdram_ba, o_sdram_dqm;
    logic [15:0] o_sdram_dq, i_sdram_dq;
    logic        o_sdram_dq_oe;
    logic [2:0]  cmd;

    sdram_fb_ctrl #(
        .INIT_WAIT      (TB_INIT_WAIT),
        .REFRESH_CYCLES (TB_REFRESH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rd_req        (i_rd_req),
        .o_rd_gnt        (o_rd_gnt),
        .i_rd_addr       (i_rd_addr),
        .o_rd_data       (o_rd_data),
        .o_rd_data_valid (o_rd_data_valid),
        .i_wr_req        (i_wr_req),
        .o_wr_gnt        (o_wr_gnt),
        .i_wr_addr       (i_wr_addr),
        .i_wr_data       (i_wr_data),
        .o_ready         (o_ready),
        .o_sdram_cke     (o_sdram_cke),
        .o_sdram_rasn    (o_sdram_rasn),
        .o_sdram_casn    (o_sdram_casn),
        .o_sdram_wen     (o_sdram_wen),
        .o_sdram_a       (o_sdram_a),
        .o_sdram_ba      (o_sdram_ba),
        .o_sdram_dqm     (o_sdram_dqm),
        .o_sdram_dq      (o_sdram_dq),
        .o_sdram_dq_oe   (o_sdram_dq_oe),
        .i_sdram_dq      (i_sdram_dq)
    );

    assign cmd = {o_sdram_rasn, o_sdram_casn, o_sdram_wen};

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM model: data for a READ is driven during the CL2 cycle only
    logic [15:0] mem [0:65535];
    logic [7:0]  open_row = 8'h00;
    int          mcyc = 0;
    int          rd_due [$];
    logic [15:0] rd_val [$];

    always @(negedge clk) begin
        mcyc = mcyc + 1;
        if (cmd == C_ACT) open_row = o_sdram_a[7:0];
        if (cmd == C_WR && o_sdram_dq_oe) mem[{open_row, o_sdram_a[7:0]}] = o_sdram_dq;
        if (cmd == C_RD) begin
            rd_due.push_back(mcyc + 2);
            rd_val.push_back(mem[{open_row, o_sdram_a[7:0]}]);
        end
        if (rd_due.size() > 0 && rd_due[0] == mcyc) begin
            i_sdram_dq = rd_val.pop_front();
            void'(rd_due.pop_front());
        end else begin
            i_sdram_dq = 16'hDEAD;
        end
    end

    int both_seen = 0;
    int gnt_unready = 0;
    always @(negedge clk) begin
        if (o_rd_gnt && o_wr_gnt) both_seen = both_seen + 1;
        if ((o_rd_gnt || o_wr_gnt) && !o_ready) gnt_unready = gnt_unready + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [15:0] exp_pat(input logic [15:0] ad);
        return (ad * 16'd7 + 16'd3) ^ 16'h5A00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cmd(output logic [2:0] c, output logic [12:0] a, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (cmd == C_NOP && gap < 400);
        c = cmd;
        a = o_sdram_a;
    endtask

    task automatic wait_gnt(input bit want_rd, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!(want_rd ? o_rd_gnt : o_wr_gnt) && gap < 100);
    endtask

    // called at the negedge where rst was just released
    task automatic check_init(input string pfx);
        int nops = 0;
        int g;
        logic [2:0]  c;
        logic [12:0] a;
        @(negedge clk);
        while (cmd == C_NOP && o_sdram_cke === 1'b1 && nops < 30000) begin
            nops++;
            @(negedge clk);
        end
        chk({pfx, "_nop_count"}, nops, EXP_WAIT);
        chk({pfx, "_pre_cmd"}, cmd, C_PRE);
        chk({pfx, "_pre_a"}, o_sdram_a, 13'h400);
        chk({pfx, "_not_ready"}, o_ready, 1'b0);
        next_cmd(c, a, g);
        chk({pfx, "_ref1"}, c, C_REF);
        chk({pfx, "_ref1_gap"}, g, 2);
        next_cmd(c, a, g);
        chk({pfx, "_ref2"}, c, C_REF);
        chk({pfx, "_ref2_gap"}, g, 8);
        next_cmd(c, a, g);
        chk({pfx, "_lmr"}, c, C_LMR);
        chk({pfx, "_lmr_gap"}, g, 8);
        chk({pfx, "_lmr_a"}, a, 13'h020);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!o_ready && g < 20);
        chk({pfx, "_ready_gap"}, g, 2);
        chk({pfx, "_dqm"}, o_sdram_dqm, 2'b00);
    endtask

    initial begin
        int g, t0, t1;
        logic [2:0]  c;
        logic [12:0] a;
        int idx, vcnt, last_g, last_ref, bad_gap, ref_seen, guard, stray;

        for (int i = 0; i < 65536; i++) mem[i] = exp_pat(16'(i));
        rst = 1'b1;
        i_rd_req = 1'b0; i_rd_addr = '0;
        i_wr_req = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        repeat (3) @(negedge clk);

        chk("rst_cke", o_sdram_cke, 1'b0);
        chk("rst_cmd", cmd, C_NOP);
        chk("rst_a", o_sdram_a, 13'h0);
        chk("rst_ba", o_sdram_ba, 2'b00);
        chk("rst_dqm", o_sdram_dqm, 2'b11);
        chk("rst_dq", o_sdram_dq, 16'h0);
        chk("rst_dq_oe", o_sdram_dq_oe, 1'b0);
        chk("rst_gnts", {o_rd_gnt, o_wr_gnt, o_rd_data_valid}, 3'b000);
        chk("rst_rd_data", o_rd_data, 16'h0);
        chk("rst_ready", o_ready, 1'b0);

        rst = 1'b0;
        check_init("init");

        // write 0x1234 @ 0xA55A, read it back
        i_wr_req = 1'b1; i_wr_addr = 16'hA55A; i_wr_data = 16'h1234;
        wait_gnt(1'b0, g);
        t0 = cyc;
        chk("wr_gnt_latency", g, 1);
        chk("wr_act_cmd", cmd, C_ACT);
        chk("wr_act_row", o_sdram_a, 13'h0A5);
        chk("wr_act_rdgnt", o_rd_gnt, 1'b0);
        i_wr_req = 1'b0;
        i_rd_req = 1'b1; i_rd_addr = 16'hA55A;
        next_cmd(c, a, g);
        chk("wr_cmd", c, C_WR);
        chk("wr_cmd_gap", g, 2);
        chk("wr_cmd_a", a, 13'h45A);
        chk("wr_dq", o_sdram_dq, 16'h1234);
        chk("wr_dq_oe", o_sdram_dq_oe, 1'b1);
        @(negedge clk);
        chk("wr_dq_oe_after", o_sdram_dq_oe, 1'b0);
        wait_gnt(1'b1, g);
        chk("rd_after_wr_spacing", cyc - t0, 8);
        chk("rd_act_cmd", cmd, C_ACT);
        chk("rd_act_row", o_sdram_a, 13'h0A5);
        i_rd_req = 1'b0;
        next_cmd(c, a, g);
        t1 = cyc;
        chk("rd_cmd", c, C_RD);
        chk("rd_cmd_gap", g, 2);
        chk("rd_cmd_a", a, 13'h45A);
        chk("rd_dq_oe", o_sdram_dq_oe, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!o_rd_data_valid && g < 10);
        chk("rd_valid_latency", cyc - t1, 3);
        chk("rd_data", o_rd_data, 16'h1234);
        @(negedge clk);
        chk("rd_valid_pulse", o_rd_data_valid, 1'b0);

        // simultaneous requests: read first, write one access later
        i_rd_req = 1'b1; i_rd_addr = 16'h0100;
        i_wr_req = 1'b1; i_wr_addr = 16'h0101; i_wr_data = 16'hBEEF;
        wait_gnt(1'b1, g);
        t0 = cyc;
        chk("sim_rd_first", o_rd_gnt, 1'b1);
        chk("sim_wr_held", o_wr_gnt, 1'b0);
        i_rd_req = 1'b0;
        wait_gnt(1'b0, g);
        chk("sim_wr_spacing", cyc - t0, 8);
        i_wr_req = 1'b0;
        next_cmd(c, a, g);
        chk("sim_wr_cmd", c, C_WR);
        chk("sim_wr_dq", o_sdram_dq, 16'hBEEF);

        // request withdrawn before it could be granted
        i_rd_req = 1'b1; i_rd_addr = 16'h2222;
        @(negedge clk);
        i_rd_req = 1'b0;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_rd_gnt || o_wr_gnt || cmd == C_ACT) stray++;
        end
        chk("dropped_req_no_access", stray, 0);

        // idle refresh spacing
        next_cmd(c, a, g);
        chk("idle_ref_cmd", c, C_REF);
        next_cmd(c, a, g);
        chk("idle_ref_cmd2", c, C_REF);
        chk("idle_ref_period", g, TB_REFRESH);

        // 64 back-to-back reads, refreshes interleaved
        idx = 0; vcnt = 0; last_g = -1; last_ref = -1000;
        bad_gap = 0; ref_seen = 0; guard = 0;
        i_rd_req = 1'b1; i_rd_addr = 16'h3300;
        while (vcnt < 64 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (cmd == C_REF) begin
                ref_seen++;
                last_ref = cyc;
            end
            if (o_rd_gnt) begin
                if (last_g >= 0) begin
                    if (!((cyc - last_g == 8 && last_ref < last_g) ||
                          (cyc - last_g == 16 && last_ref == last_g + 8))) bad_gap++;
                end
                last_g = cyc;
                idx++;
                if (idx == 64) i_rd_req = 1'b0;
                else i_rd_addr = 16'h3300 + 16'(idx);
            end
            if (o_rd_data_valid) begin
                chk($sformatf("stream_data_%0d", vcnt), o_rd_data, exp_pat(16'h3300 + 16'(vcnt)));
                vcnt++;
            end
        end
        chk("stream_valid_count", vcnt, 64);
        chk("stream_gnt_count", idx, 64);
        chk("stream_gnt_spacing", bad_gap, 0);
        chk("stream_refresh_seen", ref_seen != 0, 1'b1);

        // reset one cycle after a write grant
        repeat (10) @(negedge clk);
        i_wr_req = 1'b1; i_wr_addr = 16'h7777; i_wr_data = 16'h5555;
        wait_gnt(1'b0, g);
        chk("mid_wr_gnt", o_wr_gnt, 1'b1);
        i_wr_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_cke", o_sdram_cke, 1'b0);
        chk("mid_rst_cmd", cmd, C_NOP);
        chk("mid_rst_a", o_sdram_a, 13'h0);
        chk("mid_rst_dqm", o_sdram_dqm, 2'b11);
        chk("mid_rst_oe", o_sdram_dq_oe, 1'b0);
        chk("mid_rst_ready", o_ready, 1'b0);
        chk("mid_rst_gnt", o_wr_gnt, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_init("reinit");

        #1;
        chk("never_both_grants", both_seen, 0);
        chk("no_grant_before_ready", gnt_unready, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_fb_ctrl.md
# sdram_fb_ctrl

Single-port SDRAM controller serving the frame-buffer path: a write agent (C64 pixel words from the 15 MHz domain, via async FIFO) and a read agent (VGA refill, via async FIFO) each issue one 16-bit word request at a time. The block arbitrates between them, runs power-up init and periodic auto-refresh, and drives the SDRAM command/address/data pins. It sits in the 125 MHz domain between the two FIFO state machines and the SDRAM pads.

## Interface
- INIT_WAIT, 25000: power-up NOP cycles before init (200 us at 125 MHz).
- REFRESH_CYCLES, 960: cycles between auto-refresh commands.
- T_RCD, 2: ACTIVE to READ/WRITE cycles.
- T_RFC, 8: REFRESH duration cycles.
- T_RP, 2: PRECHARGE duration cycles.
- CAS_LATENCY, 2: programmed CL (2 or 3).
- ACCESS_CYCLES, 8: ACTIVE to IDLE return cycles for one access; must be ≥ T_RCD+CAS_LATENCY+2.
- clk  in  1  125 MHz clock.
- rst  in  1  reset; asynchronous, active-high.
- i_rd_req  in  1  read request; held until granted.
- o_rd_gnt  out  1  one-cycle grant; i_rd_addr sampled this cycle.
- i_rd_addr  in  16  word address.
- o_rd_data  out  16  read word.
- o_rd_data_valid  out  1  one-cycle strobe for o_rd_data.
- i_wr_req  in  1  write request; held until granted.
- o_wr_gnt  out  1  one-cycle grant; i_wr_addr/i_wr_data sampled this cycle.
- i_wr_addr  in  16  word address.
- i_wr_data  in  16  write word.
- o_ready  out  1  high once init completes.
- o_sdram_cke, o_sdram_rasn, o_sdram_casn, o_sdram_wen  out  1 each  SDRAM control.
- o_sdram_a  out  13; o_sdram_ba  out  2; o_sdram_dqm  out  2.
- o_sdram_dq  out  16; o_sdram_dq_oe  out  1; i_sdram_dq  in  16.

## Operation
- Commands {rasn,casn,wen}: LOADMODE 000, REFRESH 001, PRECHARGE 010, ACTIVE 011, WRITE 100, READ 101, NOP 111. csn tied low outside.
- Address map: bank 0; row = addr[15:8] on a[7:0] at ACTIVE; col = addr[7:0] on a[7:0] at READ/WRITE with a[10]=1 (auto-precharge, closed page).
- Init states: INIT_WAIT (cke=1 from first cycle, NOPs for INIT_WAIT) → INIT_PRE (PRECHARGE, a[10]=1, wait T_RP) → INIT_REF1 → INIT_REF2 (REFRESH, wait T_RFC each) → INIT_MODE (LOADMODE, a=13'h020 for CL2 / 13'h030 for CL3; BL=1, sequential; wait 2) → IDLE, o_ready=1.
- IDLE priority: refresh pending > read > write. Simultaneous rd/wr request: read granted, write stays pending.
- Access: grant cycle issues ACTIVE; NOPs; READ/WRITE at grant+T_RCD; WAIT until grant+ACCESS_CYCLES, then IDLE. Write: dq=sampled data, dq_oe=1 only in WRITE cycle. dqm=00 after init.
- Refresh timer counts down continuously from REFRESH_CYCLES after init; at zero sets pending (saturating) and reloads. Pending cleared when REFRESH issued; REFRESH state lasts T_RFC.
- Request dropped before grant: no access, no grant.

## Timing
- Reset values: cke 0, command NOP, a 0, ba 0, dqm 11, dq 0, dq_oe 0, all grants/valid 0, o_rd_data 0, o_ready 0.
- Grants never assert before o_ready, never during REFRESH/access, never both in one cycle.
- o_rd_data_valid exactly READ cycle + CAS_LATENCY + 1 (registered capture of i_sdram_dq).
- Max throughput: one access per ACCESS_CYCLES; back-to-back requests granted on the first IDLE cycle.
- rst asserted mid-operation: immediate return to reset values and INIT_WAIT; pending grants/data strobes lost; full init re-runs.

## Configuration
- SDRAM_FAST_INIT_EN defined: INIT_WAIT overridden to 16 cycles (simulation). Undefined: INIT_WAIT parameter used unchanged. Everything else identical.

## Structure
- Package sdram_fb_pkg: command encodings, mode-register words for CL2/CL3, state enum.
- Sub-module sdram_refresh_timer: down-counter plus saturating pending flag, clear input.

## Test plan
- Reset with SDRAM_FAST_INIT_EN -> NOP×16, PRECHARGE a=0x400, REFRESH×2 spaced 8, LOADMODE a=0x020, o_ready=1.
- Write 0x1234 @0xA55A then read @0xA55A -> ACTIVE a=0xA5, WRITE a=0x45A dq_oe=1, later READ; o_rd_data_valid 3 cycles after READ with 0x1234.
- rd_req and wr_req same cycle -> o_rd_gnt first, o_wr_gnt 8 cycles later, never together.
- Refresh pending with rd_req held -> REFRESH issued first, o_rd_gnt 8 cycles later.
- rst pulsed 1 cycle after WRITE-grant -> outputs at reset values same cycle, no WRITE issued, init restarts.
- 64 back-to-back reads, incrementing addresses -> grants every 8 cycles, 64 valid strobes, data in order.
